mem_delay_line: RTL and testbench
=================================

Name: mem_delay_line

Overview:
- Parametrised multi-channel delay line for aligning datapath operands in the accelerator.
- Successor to the fixed-depth shift register, adding:
  - a runtime-programmable delay,
  - a stall/enable input,
  - per-sample valid tracking,
  - a flush on reconfiguration,
  - a "primed" indication once the pipe holds a full delay's worth of samples.
- Sits between the operand fetch logic and the MAC/compute array, so skewed channels can be realigned without re-synthesis.

Parameters:
- NCH, 4, number of parallel data channels sharing one valid and one delay.
- WIDTH, 16, bits per channel.
- MAX_DEPTH, 32, maximum supported delay in enabled cycles (>=2).
- DW, $clog2(MAX_DEPTH+1), width of the delay configuration field (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance enable; the pipe shifts only when en=1.
- cfg_load  input  1  latch delay_cfg and flush the pipe.
- delay_cfg  input  DW  requested delay D, in enabled cycles.
- din_valid  input  1  valid tag for din.
- din  input  NCH*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
- dout_valid  output  1  valid tag of the delayed sample.
- dout  output  NCH*WIDTH  delayed channel data.
- primed  output  1  high once D samples have been shifted in since the last reset or reload.
- cur_delay  output  DW  effective delay currently in use.

Behaviour:
- Reset: one clock, synchronous and active-high; rst has priority over everything else.
  - All stage data and valid bits clear to 0.
  - cur_delay resets to MAX_DEPTH.
  - Fill counter clears to 0, so primed=0, dout=0, dout_valid=0 in the cycle after rst is sampled high.
- Delay clamp: the effective delay is D = delay_cfg clamped to [1, MAX_DEPTH].
  - 0 maps to 1.
  - Values above MAX_DEPTH map to MAX_DEPTH.
  - Clamping is applied when the value is latched; cur_delay shows the clamped value.
- Storage: MAX_DEPTH stages, each holding NCH*WIDTH data plus 1 valid bit.
  - When en=1: stage0 <= {din_valid, din} and stage[i] <= stage[i-1].
  - When en=0: all stages hold.
- Output: {dout_valid, dout} = stage[cur_delay-1], a registered stage mux with no combinational path from din.
  - With en held high, a sample presented at edge t appears on dout after edge t+D-1 (visible the cycle after that edge), i.e. exactly D edges of storage.
- Stall: en=0 freezes stages and the fill counter; dout is unchanged while stalled.
  - Latency counts enabled edges only.
- Reload: when cfg_load=1 (and rst=0) at an edge, cur_delay takes the clamped delay_cfg.
  - The valid bits of all stages except stage0 are cleared.
  - Data bits are left unchanged.
- Reload with en=1 in the same cycle: stage0 captures {din_valid, din} normally and the fill counter becomes 1. That sample is the first one under the new delay.
- Reload with en=0: stage0's valid is cleared as well and the fill counter becomes 0.
- Fill counter: saturating, width DW.
  - Increments on each enabled edge without reload.
  - Saturates at cur_delay.
  - primed = (fill >= cur_delay).
- Flushed samples: stale data still in flushed stages may reach dout, but always with dout_valid=0.
- Channel independence: each channel's data is delayed identically; there is no cross-channel arithmetic.
- Mid-operation reset: the pipe contents are lost and outputs clear on the next cycle; cfg_load in the same cycle is ignored.

Test Plan:
- Basic delay: reset, load D=5, en=1, feed ch0=0x0001..0x0010 all valid → ch0=0x0001 appears with dout_valid=1 exactly 5 edges after input; primed rises on the 5th enabled edge.
- Stall: D=3, en=1, feed 0xA1,0xA2,0xA3, then en=0 for 4 cycles, then en=1 → dout holds during the stall; 0xA1 emerges on the 3rd enabled edge, stall cycles not counted.
- Clamp: load delay_cfg=0 → cur_delay=1, 1-edge latency; load delay_cfg=MAX_DEPTH+1 (33 at default) → cur_delay=32, 32-edge latency.
- Reload flush: D=8 pipe full of valid data, pulse cfg_load with D=2 and en=1 in the same cycle with din=0x55 → dout_valid=0 until 0x55 exits 2 edges later; primed=0 then 1 after the 2nd edge.
- Valid gaps and channels: NCH=4, alternate din_valid 1/0, with distinct per-channel patterns 0x1111/0x2222/0x3333/0x4444 → valid pattern and each channel's data are reproduced D edges later with no channel crosstalk.
- Reset mid-stream: D=6 with data in flight, assert rst one cycle → next cycle dout=0, dout_valid=0, primed=0, cur_delay=32; cfg_load asserted together with rst has no effect.

Source files
------------

// File: rtl/mem_delay_line_if.sv
// Streaming sample bus for mem_delay_line: advance enable, tagged input sample
// and the tagged delayed sample.
interface mem_delay_line_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
);
  logic                 en;
  logic                 din_valid;
  logic [NCH*WIDTH-1:0] din;
  logic                 dout_valid;
  logic [NCH*WIDTH-1:0] dout;

  modport master (
    output en, din_valid, din,
    input  dout_valid, dout
  );

  modport slave (
    input  en, din_valid, din,
    output dout_valid, dout
  );
endinterface

// File: rtl/mem_delay_line.sv
// Multi-channel delay line with runtime-programmable delay, stall, per-sample
// valid tracking, flush on reload and a primed indication.
module mem_delay_line #(
  parameter int  NCH       = 4,
  parameter int  WIDTH     = 16,
  parameter int  MAX_DEPTH = 32,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  mem_delay_line_if.slave bus,
  input  logic            cfg_load,
  input  logic [DW-1:0]   delay_cfg,
  output logic            primed,
  output logic [DW-1:0]   cur_delay
);

  localparam int AW     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int DATA_W = NCH * WIDTH;

  logic [DATA_W-1:0]    data_q [MAX_DEPTH];
  logic [DATA_W-1:0]    data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] valid_q, valid_d;
  logic [DW-1:0]        cur_delay_q, cur_delay_d;
  logic [DW-1:0]        fill_q, fill_d;
  logic [DW-1:0]        delay_clamped;
  logic [AW-1:0]        sel;

  always_comb begin
    delay_clamped = delay_cfg;
    if (delay_cfg == '0) begin
      delay_clamped = DW'(1);
    end else if (delay_cfg > DW'(MAX_DEPTH)) begin
      delay_clamped = DW'(MAX_DEPTH);
    end
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    cur_delay_d = cur_delay_q;
    fill_d      = fill_q;

    if (bus.en) begin
      data_d[0]  = bus.din;
      valid_d[0] = bus.din_valid;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end

    // Reload invalidates everything in flight; only a sample captured on the
    // reload edge itself survives, as the first sample under the new delay.
    if (cfg_load) begin
      cur_delay_d = delay_clamped;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        valid_d[i] = 1'b0;
      end
      if (bus.en) begin
        fill_d = DW'(1);
      end else begin
        valid_d[0] = 1'b0;
        fill_d     = '0;
      end
    end else if (bus.en && (fill_q < cur_delay_q)) begin
      fill_d = fill_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q     <= '0;
      cur_delay_q <= DW'(MAX_DEPTH);
      fill_q      <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      cur_delay_q <= cur_delay_d;
      fill_q      <= fill_d;
    end
  end

  // cur_delay_q is always within [1, MAX_DEPTH], so the tap index fits AW bits.
  assign sel            = AW'(cur_delay_q - DW'(1));
  assign bus.dout       = data_q[sel];
  assign bus.dout_valid = valid_q[sel];
  assign primed         = (fill_q >= cur_delay_q);
  assign cur_delay      = cur_delay_q;

endmodule

// File: tb/tb_mem_delay_line.sv
// Directed bench for mem_delay_line: delay, stall, clamp, reload flush,
// channel independence and mid-stream reset.
module tb_mem_delay_line;
  localparam int NCH       = 4;
  localparam int WIDTH     = 16;
  localparam int MAX_DEPTH = 32;
  localparam int DW        = $clog2(MAX_DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          cfg_load;
  logic [DW-1:0] delay_cfg;
  logic          primed;
  logic [DW-1:0] cur_delay;

  int checks;
  int errors;

  mem_delay_line_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  mem_delay_line #(.NCH(NCH), .WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_load  (cfg_load),
    .delay_cfg (delay_cfg),
    .primed    (primed),
    .cur_delay (cur_delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] chan_pat(input int j);
    return {16'h4440 + 16'(j), 16'h3330 + 16'(j), 16'h2220 + 16'(j), 16'h1110 + 16'(j)};
  endfunction

  task automatic load(input int d);
    bus.en    = 1'b0;
    cfg_load  = 1'b1;
    delay_cfg = DW'(d);
    tick();
    cfg_load  = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    cfg_load      = 1'b0;
    delay_cfg     = '0;
    bus.en        = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    tick();
    rst = 1'b0;
    chk("rst_dout", bus.dout, 64'h0);
    chk("rst_valid", 64'(bus.dout_valid), 64'h0);
    chk("rst_primed", 64'(primed), 64'h0);
    chk("rst_cur_delay", 64'(cur_delay), 64'd32);

    // Basic delay D=5
    load(5);
    chk("d5_cur_delay", 64'(cur_delay), 64'd5);
    for (int k = 1; k <= 16; k++) begin
      bus.en        = 1'b1;
      bus.din_valid = 1'b1;
      bus.din       = 64'(k);
      tick();
      chk("d5_dout", bus.dout, (k >= 5) ? 64'(k - 4) : 64'h0);
      chk("d5_valid", 64'(bus.dout_valid), (k >= 5) ? 64'h1 : 64'h0);
      chk("d5_primed", 64'(primed), (k >= 5) ? 64'h1 : 64'h0);
    end

    // Stall with D=3: A1, A2, four stalled cycles, then A3
    load(3);
    chk("st_flush_valid", 64'(bus.dout_valid), 64'h0);
    bus.en = 1'b1; bus.din_valid = 1'b1; bus.din = 64'hA1; tick();
    bus.din = 64'hA2; tick();
    chk("st_pre_dout", bus.dout, 64'h10);
    chk("st_pre_valid", 64'(bus.dout_valid), 64'h0);
    chk("st_pre_primed", 64'(primed), 64'h0);
    for (int k = 0; k < 4; k++) begin
      bus.en  = 1'b0;
      bus.din = 64'hFF;
      tick();
      chk("st_hold_dout", bus.dout, 64'h10);
      chk("st_hold_valid", 64'(bus.dout_valid), 64'h0);
      chk("st_hold_primed", 64'(primed), 64'h0);
    end
    bus.en = 1'b1; bus.din = 64'hA3; tick();
    chk("st_a1_dout", bus.dout, 64'hA1);
    chk("st_a1_valid", 64'(bus.dout_valid), 64'h1);
    chk("st_a1_primed", 64'(primed), 64'h1);
    bus.din = 64'hA4; tick();
    chk("st_a2_dout", bus.dout, 64'hA2);

    // Clamp low: 0 -> 1
    load(0);
    chk("cl0_cur_delay", 64'(cur_delay), 64'd1);
    chk("cl0_valid", 64'(bus.dout_valid), 64'h0);
    chk("cl0_primed", 64'(primed), 64'h0);
    bus.en = 1'b1; bus.din_valid = 1'b1; bus.din = 64'h0B0B; tick();
    chk("cl0_dout", bus.dout, 64'h0B0B);
    chk("cl0_valid1", 64'(bus.dout_valid), 64'h1);
    chk("cl0_primed1", 64'(primed), 64'h1);

    // Clamp high: 33 -> 32
    load(33);
    chk("cl33_cur_delay", 64'(cur_delay), 64'd32);
    chk("cl33_primed", 64'(primed), 64'h0);
    for (int j = 1; j <= 33; j++) begin
      bus.en = 1'b1; bus.din_valid = 1'b1; bus.din = 64'(32'h100 + j);
      tick();
      if (j >= 31) begin
        chk("cl33_valid", 64'(bus.dout_valid), (j >= 32) ? 64'h1 : 64'h0);
        chk("cl33_primed", 64'(primed), (j >= 32) ? 64'h1 : 64'h0);
      end
      if (j >= 32) chk("cl33_dout", bus.dout, 64'(32'h100 + j - 31));
    end

    // Reload flush: full D=8 pipe, reload to D=2 with en=1 and din=0x55
    load(8);
    for (int j = 1; j <= 8; j++) begin
      bus.en = 1'b1; bus.din_valid = 1'b1; bus.din = 64'(32'h200 + j);
      tick();
    end
    chk("rl_full_dout", bus.dout, 64'h201);
    chk("rl_full_valid", 64'(bus.dout_valid), 64'h1);
    chk("rl_full_primed", 64'(primed), 64'h1);
    cfg_load = 1'b1; delay_cfg = DW'(2);
    bus.en = 1'b1; bus.din_valid = 1'b1; bus.din = 64'h55;
    tick();
    cfg_load = 1'b0;
    chk("rl_cur_delay", 64'(cur_delay), 64'd2);
    chk("rl_flush_valid", 64'(bus.dout_valid), 64'h0);
    chk("rl_flush_primed", 64'(primed), 64'h0);
    bus.din = 64'h66; tick();
    chk("rl_55_dout", bus.dout, 64'h55);
    chk("rl_55_valid", 64'(bus.dout_valid), 64'h1);
    chk("rl_55_primed", 64'(primed), 64'h1);

    // Valid gaps and channel independence, D=4
    load(4);
    for (int j = 1; j <= 10; j++) begin
      bus.en = 1'b1; bus.din_valid = j[0]; bus.din = chan_pat(j);
      tick();
      if (j >= 4) begin
        chk("ch_dout", bus.dout, chan_pat(j - 3));
        chk("ch_valid", 64'(bus.dout_valid), 64'((j - 3) % 2));
      end else begin
        chk("ch_fill_valid", 64'(bus.dout_valid), 64'h0);
      end
      chk("ch_primed", 64'(primed), (j >= 4) ? 64'h1 : 64'h0);
    end

    // Mid-stream reset with a concurrent reload that must be ignored
    load(6);
    for (int j = 1; j <= 4; j++) begin
      bus.en = 1'b1; bus.din_valid = 1'b1; bus.din = 64'(32'h300 + j);
      tick();
    end
    rst = 1'b1; cfg_load = 1'b1; delay_cfg = DW'(3); bus.din = 64'h399;
    tick();
    rst = 1'b0; cfg_load = 1'b0;
    chk("mr_dout", bus.dout, 64'h0);
    chk("mr_valid", 64'(bus.dout_valid), 64'h0);
    chk("mr_primed", 64'(primed), 64'h0);
    chk("mr_cur_delay", 64'(cur_delay), 64'd32);
    bus.din = 64'h3AA; tick();
    chk("mr_after_cur_delay", 64'(cur_delay), 64'd32);
    chk("mr_after_valid", 64'(bus.dout_valid), 64'h0);
    chk("mr_after_dout", bus.dout, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
